// File: rtl/cpu_monitor_pkg.sv
// Shared types and constants for the LEGv8 run-control / trace monitor.
package cpu_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUN     = 2'b01,
        ST_HALTED  = 2'b10,
        ST_TIMEOUT = 2'b11
    } run_state_t;

    localparam logic [31:0] HALT_INSN_DEFAULT = 32'hD4400000;

    function automatic int trace_entry_w(input int aw, input int iw);
        return aw + iw;
    endfunction

endpackage

// File: rtl/cpu_run_monitor_trace_fifo.sv
// First-word fall-through trace FIFO; a push into a full FIFO is dropped
// (drop strobe) unless the head is popped on the same edge.
module trace_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] dout,
    output logic             drop
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             pop_ok;
    logic             push_ok;

    assign full    = (count == CW'(DEPTH));
    assign valid   = (count != '0);
    assign pop_ok  = pop && valid;
    // When full, a simultaneous pop frees the slot the write lands in.
    assign push_ok = push && (!full || pop_ok);
    assign drop    = push && !push_ok;
    assign dout    = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop_ok)      count <= count + 1'b1;
            else if (pop_ok && !push_ok) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/cpu_run_monitor.sv
// Run-control and instruction-trace monitor for LEGv8 CPU benches.
// Define CPU_RUN_MONITOR_TRACE_EN to compile in the trace FIFO and overflow flag.
module cpu_run_monitor
    import cpu_monitor_pkg::*;
#(
    parameter int             AW          = 32,
    parameter int             IW          = 32,
    parameter int             DEPTH       = 16,
    parameter int             MAX_CYCLES  = 1000,
    parameter int             STALL_LIMIT = 4,
    parameter logic [IW-1:0]  HALT_INSN   = IW'(HALT_INSN_DEFAULT)
) (
    input  logic                             clocc,
    input  logic                             reset,
    input  logic                             start,
    input  logic [AW-1:0]                    address,
    input  logic [IW-1:0]                    instruction,
    output logic [AW+IW-1:0]                 trace_data,
    output logic                             trace_valid,
    input  logic                             trace_ready,
    output logic [1:0]                       state,
    output logic [$clog2(MAX_CYCLES+1)-1:0]  cycle_count,
    output logic                             stop,
    output logic                             overflow
);

    localparam int CCW = $clog2(MAX_CYCLES + 1);
    localparam int SCW = $clog2(STALL_LIMIT + 1);
    localparam int TW  = trace_entry_w(AW, IW);

    run_state_t     state_q;
    logic [SCW-1:0] stall_cnt;
    logic [SCW-1:0] stall_next;
    logic [CCW-1:0] cnt_next;
    logic [AW-1:0]  prev_addr;
    logic           prev_vld;
    logic           same_addr;
    logic           push;
    logic           restart;

    assign push    = (state_q == ST_RUN);
    assign restart = start && (state_q == ST_HALTED || state_q == ST_TIMEOUT);
    assign state   = state_q;

    always_comb begin
        same_addr  = prev_vld && (address == prev_addr);
        stall_next = same_addr ? stall_cnt + 1'b1 : '0;
        cnt_next   = cycle_count + 1'b1;
    end

    always_ff @(posedge clocc or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cycle_count <= '0;
            stall_cnt   <= '0;
            prev_vld    <= 1'b0;
            stop        <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) state_q <= ST_RUN;
                end
                ST_RUN: begin
                    cycle_count <= cnt_next;
                    stall_cnt   <= stall_next;
                    prev_vld    <= 1'b1;
                    // HLT outranks a stall, which outranks the cycle budget.
                    if (instruction == HALT_INSN || stall_next == SCW'(STALL_LIMIT)) begin
                        state_q <= ST_HALTED;
                        stop    <= 1'b1;
                    end else if (cnt_next == CCW'(MAX_CYCLES)) begin
                        state_q <= ST_TIMEOUT;
                        stop    <= 1'b1;
                    end
                end
                default: begin
                    if (restart) begin
                        state_q     <= ST_RUN;
                        cycle_count <= '0;
                        stall_cnt   <= '0;
                        prev_vld    <= 1'b0;
                        stop        <= 1'b0;
                    end
                end
            endcase
        end
    end

    // prev_addr is only meaningful while prev_vld is set.
    always_ff @(posedge clocc) begin
        if (push) prev_addr <= address;
    end

`ifdef CPU_RUN_MONITOR_TRACE_EN
    logic fifo_drop;
    logic fifo_full_unused;

    trace_fifo #(
        .WIDTH (TW),
        .DEPTH (DEPTH)
    ) u_trace_fifo (
        .clk   (clocc),
        .rst_n (reset),
        .push  (push),
        .din   ({address, instruction}),
        .full  (fifo_full_unused),
        .pop   (trace_ready),
        .valid (trace_valid),
        .dout  (trace_data),
        .drop  (fifo_drop)
    );

    always_ff @(posedge clocc or negedge reset) begin
        if (!reset)         overflow <= 1'b0;
        else if (restart)   overflow <= 1'b0;
        else if (fifo_drop) overflow <= 1'b1;
    end
`else
    logic unused_trace;

    assign unused_trace = &{1'b0, trace_ready, push};
    assign trace_data   = TW'(0);
    assign trace_valid  = 1'b0;
    assign overflow     = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Directed self-checking bench for cpu_run_monitor (MAX_CYCLES=20, DEPTH=16, STALL_LIMIT=4).
module tb_cpu_run_monitor;

`ifdef CPU_RUN_MONITOR_TRACE_EN
    localparam bit TR = 1'b1;
`else
    localparam bit TR = 1'b0;
`endif
    localparam logic [31:0] HLT = 32'hD4400000;

    logic        clocc;
    logic        reset;
    logic        start;
    logic [31:0] address;
    logic [31:0] instruction;
    logic [63:0] trace_data;
    logic        trace_valid;
    logic        trace_ready;
    logic [1:0]  state;
    logic [4:0]  cycle_count;
    logic        stop;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    cpu_run_monitor #(
        .AW(32), .IW(32), .DEPTH(16), .MAX_CYCLES(20), .STALL_LIMIT(4), .HALT_INSN(HLT)
    ) dut (
        .clocc(clocc), .reset(reset), .start(start), .address(address),
        .instruction(instruction), .trace_data(trace_data), .trace_valid(trace_valid),
        .trace_ready(trace_ready), .state(state), .cycle_count(cycle_count),
        .stop(stop), .overflow(overflow)
    );

    initial clocc = 1'b0;
    always #5 clocc = ~clocc;

    task automatic tick;
        @(posedge clocc);
        #1;
    endtask

    task automatic sample(input logic [31:0] a, input logic [31:0] i);
        address     = a;
        instruction = i;
        tick();
    endtask

    task automatic do_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_reset;
        #2 reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        do_reset();
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL rst_state got %0h exp 0", state); end
        checks++; if (cycle_count !== 5'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", cycle_count); end
        checks++; if (stop !== 1'b0) begin errors++; $display("FAIL rst_stop got %0b exp 0", stop); end
        checks++; if (trace_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b exp 0", trace_valid); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow got %0b exp 0", overflow); end
        checks++; if (trace_data !== 64'h0) begin errors++; $display("FAIL rst_data got %0h exp 0", trace_data); end
        start = 1'b0;
        tick();
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL idle_hold got %0h exp 0", state); end
    endtask

    task automatic test_hlt;
        logic [63:0] exp;
        do_start();
        checks++; if (state !== 2'b01 || cycle_count !== 5'd0) begin errors++; $display("FAIL hlt_enter state %0h count %0d exp 1/0", state, cycle_count); end
        for (int k = 0; k < 6; k++) begin
            sample(32'(4 * k), (k == 5) ? HLT : 32'h8B000000 + 32'(k));
            checks++;
            if (cycle_count !== 5'(k + 1) || state !== ((k == 5) ? 2'b10 : 2'b01))
                begin errors++; $display("FAIL hlt_step%0d count %0d state %0h exp %0d/%0h", k, cycle_count, state, k + 1, (k == 5) ? 2 : 1); end
        end
        checks++; if (stop !== 1'b1) begin errors++; $display("FAIL hlt_stop got %0b exp 1", stop); end
        sample(32'h40, 32'h0);
        checks++; if (cycle_count !== 5'd6 || state !== 2'b10) begin errors++; $display("FAIL hlt_frozen count %0d state %0h exp 6/2", cycle_count, state); end
        trace_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            exp = TR ? {32'(4 * k), (k == 5) ? HLT : 32'h8B000000 + 32'(k)} : 64'h0;
            checks++;
            if (trace_valid !== TR || trace_data !== exp)
                begin errors++; $display("FAIL hlt_drain%0d got %0b/%0h exp %0b/%0h", k, trace_valid, trace_data, TR, exp); end
            tick();
        end
        checks++; if (trace_valid !== 1'b0) begin errors++; $display("FAIL hlt_empty got %0b exp 0", trace_valid); end
        trace_ready = 1'b0;
    endtask

    task automatic test_stall;
        logic [31:0] addrs [7];
        logic [63:0] exp;
        addrs = '{32'h0, 32'h4, 32'h8, 32'h8, 32'h8, 32'h8, 32'h8};
        start = 1'b1;
        tick();
        checks++; if (state !== 2'b01 || stop !== 1'b0) begin errors++; $display("FAIL stall_restart state %0h stop %0b exp 1/0", state, stop); end
        for (int k = 0; k < 7; k++) begin
            if (k == 3) start = 1'b0;
            sample(addrs[k], 32'hCB000000 + 32'(k));
            checks++;
            if (cycle_count !== 5'(k + 1) || state !== ((k == 6) ? 2'b10 : 2'b01))
                begin errors++; $display("FAIL stall_step%0d count %0d state %0h exp %0d/%0h", k, cycle_count, state, k + 1, (k == 6) ? 2 : 1); end
        end
        trace_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            exp = TR ? {addrs[k], 32'hCB000000 + 32'(k)} : 64'h0;
            checks++;
            if (trace_data !== exp) begin errors++; $display("FAIL stall_drain%0d got %0h exp %0h", k, trace_data, exp); end
            tick();
        end
        checks++; if (trace_valid !== 1'b0) begin errors++; $display("FAIL stall_empty got %0b exp 0", trace_valid); end
        trace_ready = 1'b0;
    endtask

    task automatic test_timeout_overflow;
        do_start();
        for (int k = 0; k < 20; k++) begin
            sample(32'h100 + 32'(4 * k), 32'h91000000 + 32'(k));
            if (k == 15) begin
                checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_at16 got %0b exp 0", overflow); end
            end
            if (k == 16) begin
                checks++; if (overflow !== TR) begin errors++; $display("FAIL ovf_at17 got %0b exp %0b", overflow, TR); end
            end
            if (k == 18) begin
                checks++; if (state !== 2'b01) begin errors++; $display("FAIL to_pre state %0h exp 1", state); end
            end
        end
        checks++; if (state !== 2'b11 || cycle_count !== 5'd20 || stop !== 1'b1)
            begin errors++; $display("FAIL timeout state %0h count %0d stop %0b exp 3/20/1", state, cycle_count, stop); end
        checks++; if (overflow !== TR) begin errors++; $display("FAIL to_overflow got %0b exp %0b", overflow, TR); end
        do_start();
        checks++; if (state !== 2'b01 || cycle_count !== 5'd0 || overflow !== 1'b0)
            begin errors++; $display("FAIL to_restart state %0h count %0d ovf %0b exp 1/0/0", state, cycle_count, overflow); end
        checks++; if (trace_valid !== TR || trace_data !== (TR ? {32'h100, 32'h91000000} : 64'h0))
            begin errors++; $display("FAIL to_kept got %0b/%0h exp %0b", trace_valid, trace_data, TR); end
    endtask

    task automatic test_full_passthrough;
        logic [63:0] exp;
        trace_ready = 1'b1;
        for (int j = 0; j < 13; j++) begin
            exp = TR ? {32'h100 + 32'(4 * j), 32'h91000000 + 32'(j)} : 64'h0;
            checks++;
            if (trace_data !== exp) begin errors++; $display("FAIL full_pop%0d got %0h exp %0h", j, trace_data, exp); end
            sample(32'h200 + 32'(4 * j), (j == 12) ? HLT : 32'hAA000000 + 32'(j));
        end
        checks++; if (state !== 2'b10 || cycle_count !== 5'd13 || overflow !== 1'b0)
            begin errors++; $display("FAIL full_end state %0h count %0d ovf %0b exp 2/13/0", state, cycle_count, overflow); end
        for (int m = 0; m < 16; m++) begin
            if (m < 3) exp = {32'h100 + 32'(4 * (13 + m)), 32'h91000000 + 32'(13 + m)};
            else       exp = {32'h200 + 32'(4 * (m - 3)), (m == 15) ? HLT : 32'hAA000000 + 32'(m - 3)};
            if (!TR) exp = 64'h0;
            checks++;
            if (trace_valid !== TR || trace_data !== exp)
                begin errors++; $display("FAIL full_drain%0d got %0b/%0h exp %0b/%0h", m, trace_valid, trace_data, TR, exp); end
            tick();
        end
        checks++; if (trace_valid !== 1'b0) begin errors++; $display("FAIL full_empty got %0b exp 0", trace_valid); end
        trace_ready = 1'b0;
    endtask

    task automatic test_simultaneous;
        do_start();
        for (int k = 0; k < 20; k++) begin
            sample(32'h300 + 32'(4 * k), (k == 19) ? HLT : 32'h8B000000 + 32'(k));
            if (k == 18) begin
                checks++; if (state !== 2'b01) begin errors++; $display("FAIL sim_pre state %0h exp 1", state); end
            end
        end
        checks++; if (state !== 2'b10 || cycle_count !== 5'd20 || stop !== 1'b1)
            begin errors++; $display("FAIL sim_halt state %0h count %0d stop %0b exp 2/20/1", state, cycle_count, stop); end
        checks++; if (overflow !== TR || trace_valid !== TR)
            begin errors++; $display("FAIL sim_trace ovf %0b valid %0b exp %0b", overflow, trace_valid, TR); end
    endtask

    task automatic test_reset_midrun;
        do_reset();
        do_start();
        for (int k = 0; k < 7; k++) begin
            trace_ready = (k >= 3);
            sample(32'h500 + 32'(4 * k), 32'h8B000000);
        end
        checks++; if (state !== 2'b01 || cycle_count !== 5'd7 || trace_valid !== TR)
            begin errors++; $display("FAIL mid_pre state %0h count %0d valid %0b exp 1/7/%0b", state, cycle_count, trace_valid, TR); end
        #2 reset = 1'b0;
        #1;
        checks++; if (state !== 2'b00 || cycle_count !== 5'd0 || stop !== 1'b0)
            begin errors++; $display("FAIL mid_rst state %0h count %0d stop %0b exp 0/0/0", state, cycle_count, stop); end
        checks++; if (trace_valid !== 1'b0 || overflow !== 1'b0 || trace_data !== 64'h0)
            begin errors++; $display("FAIL mid_rst_trace valid %0b ovf %0b data %0h exp 0", trace_valid, overflow, trace_data); end
        trace_ready = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        checks++; if (state !== 2'b00 || cycle_count !== 5'd0) begin errors++; $display("FAIL mid_after state %0h count %0d exp 0/0", state, cycle_count); end
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        address     = 32'h0;
        instruction = 32'h0;
        trace_ready = 1'b0;
        test_reset();
        test_hlt();
        test_stall();
        test_timeout_overflow();
        test_full_passthrough();
        test_simultaneous();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_run_monitor.md
# cpu_run_monitor

Parametrised run-control and instruction-trace monitor for the LEGv8 CPU benches. It taps the CPU fetch address and instruction each clock and counts executed cycles. It detects end-of-program by HLT opcode, branch-to-self stall or cycle timeout, and raises a `stop` flag the bench polls in place of a fixed-delay `$stop`. An optional trace FIFO buffers `{address, instruction}` pairs for drain over a valid/ready port.

## Interface
- `AW`, 32: fetch address width
- `IW`, 32: instruction width
- `DEPTH`, 16: trace FIFO entries; power of two, ≥2
- `MAX_CYCLES`, 1000: RUN samples before timeout; ≥1
- `STALL_LIMIT`, 4: consecutive repeated-address samples that count as halt; ≥1
- `HALT_INSN`, 32'hD4400000: HLT #0 encoding
- `clocc` in 1: clock, rising edge
- `reset` in 1: asynchronous, active-low reset
- `start` in 1: begin run; single-cycle pulse or level
- `address` in AW: CPU fetch address, sampled every RUN cycle
- `instruction` in IW: CPU fetched instruction, sampled with `address`
- `trace_data` out AW+IW: FIFO head `{address, instruction}`; 0 when empty
- `trace_valid` out 1: FIFO non-empty
- `trace_ready` in 1: consumer pops head when `trace_valid` is high
- `state` out 2: IDLE=00, RUN=01, HALTED=10, TIMEOUT=11
- `cycle_count` out $clog2(MAX_CYCLES+1): RUN samples taken
- `stop` out 1: state is HALTED or TIMEOUT
- `overflow` out 1: sticky; a trace push was dropped

## Operation
- IDLE: counters hold 0. `start`=1 → RUN.
- RUN, each cycle: sample taken. `cycle_count`+1. Push `{address, instruction}`. Stall compare runs against the previous sample; the first RUN sample has no predecessor. `start` is ignored.
- Stall counter: +1 when `address` equals the previous sample's address, else 0.
- Exit priority, evaluated on the current sample:
  - `instruction`==HALT_INSN → HALTED.
  - Else stall counter reaches STALL_LIMIT → HALTED.
  - Else `cycle_count` reaches MAX_CYCLES → TIMEOUT.
- The triggering sample is counted and pushed.
- HALTED/TIMEOUT: counters frozen, no pushes, FIFO keeps draining. `start`=1 → RUN with `cycle_count`, stall counter, previous-address valid flag and `overflow` cleared. FIFO contents are kept.
- FIFO: first-word fall-through.
  - Push when full and no pop → drop the entry, set `overflow`.
  - Push and pop in the same cycle while full → both succeed, no overflow.
  - Pop when empty → ignored.
  - Pointers wrap modulo DEPTH. Occupancy is $clog2(DEPTH+1) bits.
- Reset (any time, including mid-run): state IDLE, all counters 0, FIFO emptied, all outputs 0.

## Timing
- `state`, `stop`, `cycle_count` update on the clock edge that takes the sample. A HLT sampled at edge N gives `stop`=1 after edge N.
- Pushed entry is visible on `trace_valid`/`trace_data` after the same edge. Zero-latency pass-through is not supported.
- Pop takes effect at the edge where `trace_valid && trace_ready`.
- `start` → RUN: the first sample is taken on the edge after the one that registered RUN.

## Configuration
- `CPU_RUN_MONITOR_TRACE_EN` defined: trace FIFO and `overflow` logic compiled in.
- Not defined: no FIFO storage. `trace_valid`, `trace_data`, `overflow` are tied 0 and `trace_ready` is ignored. Run control and counters are unchanged.

## Structure
- Package `cpu_monitor_pkg` holds:
  - the state type with its 2-bit encodings
  - `HALT_INSN_DEFAULT`
  - a trace-entry width helper function
- Sub-module `trace_fifo`: parametrised by width and DEPTH, with push/full, pop/valid and an overflow strobe. It is instantiated only under `CPU_RUN_MONITOR_TRACE_EN`.

## Test plan
- Reset mid-run: RUN at `cycle_count`=7 with 3 FIFO entries, then pulse `reset` low → state 00, `cycle_count` 0, `stop` 0, `trace_valid` 0, `overflow` 0.
- HLT detect: `start`, addresses 0x0,0x4,…,0x14 with 0xD4400000 at 0x14 → HALTED, `cycle_count`=6, `stop`=1. Drain yields 6 entries, first {0x0,insn0}, last {0x14,0xD4400000}.
- Branch-to-self (STALL_LIMIT=4): addresses 0x0,0x4,0x8,0x8,0x8,0x8,0x8 → HALTED after the 7th sample, `cycle_count`=7.
- Timeout plus overflow (MAX_CYCLES=20, DEPTH=16, `trace_ready`=0, distinct addresses) → TIMEOUT, `cycle_count`=20, 16 entries, `overflow`=1. Re-`start` clears `overflow` and `cycle_count`, and the FIFO still holds 16.
- Full FIFO with `trace_ready`=1 during RUN → occupancy stays 16, `overflow` stays 0, popped order is strictly FIFO.
- Simultaneous triggers (MAX_CYCLES=20, HLT on the 20th sample) → HALTED, not TIMEOUT. Repeat the build without the macro: `trace_valid` is constantly 0 and run control behaves identically.
